vga_rx_timing: RTL and testbench

- Receive-side counterpart of the VGA sync/pixel generator.
- Samples hsync, vsync and rgb on the pixel tick and locks to the expected 640x480 timing.
- Recovers pixel coordinates, a data-enable, and start-of-frame/end-of-line strobes. Measures line and frame lengths.
- Sits on the loopback or capture path so generated video can be checked in-system (frame compare, CRC, framebuffer write).

---
 rtl/vga_rx_pkg.sv | 42 ++++
 rtl/vga_rx_crc16.sv | 39 +++
 rtl/vga_rx_timing.sv | 235 +++++++++++++++++++++++
 tb/tb_vga_rx_timing.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared types and constants for the VGA receive timing block.
//   rx_state_e     receiver lock FSM encoding
//   DEF_*          default 640x480 @ 800x525 timing
//   CNT_W/CNT_MAX  counter width and saturation value (11-bit unsigned)
//   CRC16_*        CRC-16/CCITT polynomial and seed, plus a 16-bit step function
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    localparam int DEF_CD       = 12;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_SYNC_POL = 0;

    localparam int               CNT_W   = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = 11'h7FF;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // MSB-first, non-reflected CCITT update over one 16-bit word.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// vga_rx_crc16: running CRC-16/CCITT over received pixels.
// Only built when VGA_RX_CRC_EN is defined; otherwise this file is empty.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous reset, active-high (CRC returns to seed)
//   en_i    fold data_i into the running CRC this clock
//   clr_i   restart from the seed (wins over en_i)
//   data_i  16-bit pixel word
//   crc_o   running CRC
`ifdef VGA_RX_CRC_EN
module vga_rx_crc16
    import vga_rx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i)     crc_d = CRC16_INIT;
        else if (en_i) crc_d = crc16_step(crc_q, data_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) crc_q <= CRC16_INIT;
        else       crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule
`endif

// File: rtl/vga_rx_timing.sv
// vga_rx_timing: locks to incoming VGA sync timing and recovers pixel
// coordinates, data-enable and frame/line strobes; measures line/frame length.
// Optional per-frame CRC of active pixels when VGA_RX_CRC_EN is defined
// (otherwise frame_crc_o is tied to 0).
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   pix_tick_i            pixel strobe qualifying all sampling
//   hsync_i, vsync_i      sync inputs, asserted level SYNC_POL
//   rgb_i                 pixel colour
//   pix_vld_o             pulse: x/y/de/pix_rgb updated
//   x_o, y_o              active column/row (0 outside the active area)
//   de_o                  active pixel while locked
//   pix_rgb_o             registered colour, 0 when de_o=0
//   sof_o, eol_o          first pixel of frame / last pixel of line (locked only)
//   locked_o              FSM in LOCKED
//   err_o                 pulse on timing mismatch or line counter saturation
//   h_meas_o, v_meas_o    last measured line length (ticks) / frame length (lines)
//   frame_crc_o           CRC of the last clean locked frame
//
// state  | meaning
// SEARCH | waiting for a vsync assertion edge
// CHECK  | one frame being measured against the expected totals
// LOCKED | timing verified; de/sof/eol enabled, checks continue
module vga_rx_timing
    import vga_rx_pkg::*;
#(
    parameter int CD       = DEF_CD,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             pix_tick_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [CD-1:0]    rgb_i,
    output logic             pix_vld_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             de_o,
    output logic [CD-1:0]    pix_rgb_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] h_meas_o,
    output logic [CNT_W-1:0] v_meas_o,
    output logic [15:0]      frame_crc_o
);

    localparam logic             SYNC_LVL = (SYNC_POL != 0);
    localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_END    = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_END    = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_TOT    = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_TOT    = CNT_W'(V_TOTAL);

    rx_state_e        state_q, state_d;
    logic             hs_q, vs_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] h_meas_q, h_meas_d;
    logic [CNT_W-1:0] v_meas_q, v_meas_d;
    logic             skip_q, skip_d;
    logic             pix_vld_q;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             de_q, de_d;
    logic [CD-1:0]    pix_rgb_q, pix_rgb_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             locked_q;
    logic             err_q, err_d;

    logic             hs_edge, vs_edge;
    logic             sat_err, h_bad, v_bad, fail;
    logic [CNT_W-1:0] h_len, v_len;
    logic             h_act, v_act;

    always_comb begin
        hs_edge = pix_tick_i && (hsync_i == SYNC_LVL) && (hs_q != SYNC_LVL);
        vs_edge = pix_tick_i && (vsync_i == SYNC_LVL) && (vs_q != SYNC_LVL);

        // Lengths include the tick that ends the line/frame.
        h_len = h_cnt_q + 11'd1;
        v_len = v_cnt_q + 11'd1;

        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        h_meas_d = h_meas_q;
        v_meas_d = v_meas_q;
        sat_err  = 1'b0;
        if (pix_tick_i) begin
            if (hs_edge) begin
                h_cnt_d = '0;
            end else if (h_cnt_q != CNT_MAX) begin
                h_cnt_d = h_len;
                sat_err = (h_len == CNT_MAX);
            end
            // A coincident vsync edge makes this line 0.
            if (vs_edge)                             v_cnt_d = '0;
            else if (hs_edge && v_cnt_q != CNT_MAX) v_cnt_d = v_len;
            if (hs_edge) h_meas_d = h_len;
            if (vs_edge) v_meas_d = v_len;
        end

        // The line that ends first after entering CHECK began unaligned.
        skip_d = skip_q;
        if (state_q == SEARCH && vs_edge) skip_d = 1'b1;
        else if (hs_edge)                 skip_d = 1'b0;

        h_bad = hs_edge && !skip_q && (h_len != H_TOT);
        v_bad = vs_edge && (v_len != V_TOT);
        fail  = (state_q != SEARCH) && (h_bad || v_bad);

        state_d = state_q;
        if (pix_tick_i) begin
            case (state_q)
                SEARCH:  if (vs_edge) state_d = CHECK;
                CHECK: begin
                    if (fail)         state_d = SEARCH;
                    else if (vs_edge) state_d = LOCKED;
                end
                LOCKED:  if (fail) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
            if (sat_err) state_d = SEARCH;
        end
        err_d = fail || sat_err;

        h_act = (h_cnt_d >= H_START) && (h_cnt_d < H_END);
        v_act = (v_cnt_d >= V_START) && (v_cnt_d < V_END);
        x_d   = '0;
        y_d   = '0;
        if (h_act && v_act) begin
            x_d = h_cnt_d - H_START;
            y_d = v_cnt_d - V_START;
        end
        de_d      = h_act && v_act && (state_d == LOCKED);
        pix_rgb_d = de_d ? rgb_i : '0;
        sof_d     = de_d && (x_d == '0) && (y_d == '0);
        eol_d     = de_d && (x_d == H_LAST);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= SEARCH;
            hs_q      <= ~SYNC_LVL;
            vs_q      <= ~SYNC_LVL;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_meas_q  <= '0;
            v_meas_q  <= '0;
            skip_q    <= 1'b0;
            pix_vld_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            de_q      <= 1'b0;
            pix_rgb_q <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            h_meas_q  <= h_meas_d;
            v_meas_q  <= v_meas_d;
            skip_q    <= skip_d;
            pix_vld_q <= pix_tick_i;
            sof_q     <= pix_tick_i && sof_d;
            eol_q     <= pix_tick_i && eol_d;
            err_q     <= err_d;
            if (pix_tick_i) begin
                hs_q      <= hsync_i;
                vs_q      <= vsync_i;
                x_q       <= x_d;
                y_q       <= y_d;
                de_q      <= de_d;
                pix_rgb_q <= pix_rgb_d;
                locked_q  <= (state_d == LOCKED);
            end
        end
    end

    assign pix_vld_o = pix_vld_q;
    assign x_o       = x_q;
    assign y_o       = y_q;
    assign de_o      = de_q;
    assign pix_rgb_o = pix_rgb_q;
    assign sof_o     = sof_q;
    assign eol_o     = eol_q;
    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign h_meas_o  = h_meas_q;
    assign v_meas_o  = v_meas_q;

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_run;
    logic [15:0] frame_crc_q;

    vga_rx_crc16 u_crc (
        .clk_i  (clk_i),
        .rst_i  (reset_i),
        .en_i   (pix_tick_i && de_d),
        .clr_i  (vs_edge),
        .data_i (16'(rgb_i)),
        .crc_o  (crc_run)
    );

    // Publish only frames that stayed locked through to this vsync edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            frame_crc_q <= '0;
        else if (vs_edge && state_q == LOCKED && state_d == LOCKED)
            frame_crc_q <= crc_run;
    end

    assign frame_crc_o = frame_crc_q;
`else
    assign frame_crc_o = '0;
`endif

endmodule

// File: tb/tb_vga_rx_timing.sv
// Bench for vga_rx_timing using a reduced 28x16 raster (16x8 active) so whole
// frames stay short. Every pixel tick pushes its expected outputs, derived
// from the generator's own (h, v) position, and a monitor pops them on pix_vld.
module tb_vga_rx_timing;

    localparam int CD = 12;
    localparam int HA = 16, HS = 4, HB = 4, HT = 28;
    localparam int VA = 8,  VS = 2, VB = 3, VT = 16;
    localparam int POL = 0;
    localparam logic POL_L = 1'b0;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_tick;
    logic          hsync, vsync;
    logic [CD-1:0] rgb;
    logic          pix_vld;
    logic [10:0]   x, y;
    logic          de;
    logic [CD-1:0] pix_rgb;
    logic          sof, eol, locked, err;
    logic [10:0]   h_meas, v_meas;
    logic [15:0]   frame_crc;

    always #5 clk = ~clk;

    vga_rx_timing #(
        .CD(CD), .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT), .SYNC_POL(POL)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .pix_tick_i  (pix_tick),
        .hsync_i     (hsync),
        .vsync_i     (vsync),
        .rgb_i       (rgb),
        .pix_vld_o   (pix_vld),
        .x_o         (x),
        .y_o         (y),
        .de_o        (de),
        .pix_rgb_o   (pix_rgb),
        .sof_o       (sof),
        .eol_o       (eol),
        .locked_o    (locked),
        .err_o       (err),
        .h_meas_o    (h_meas),
        .v_meas_o    (v_meas),
        .frame_crc_o (frame_crc)
    );

    typedef struct packed {
        logic [10:0]   x;
        logic [10:0]   y;
        logic          de;
        logic [CD-1:0] prgb;
        logic          sof;
        logic          eol;
        logic          locked;
        logic          err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        got, want;
    int          errors = 0;
    int          checks = 0;
    int          de_cnt = 0, eol_cnt = 0, sof_cnt = 0, err_cnt = 0;
    logic [10:0] h_meas_at_err = '0;
    int          tick_div = 4;

    always @(negedge clk) begin
        if (pix_vld) begin
            got = {x, y, de, pix_rgb, sof, eol, locked, err};
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow: pix_vld with queue size %0d, required > 0", sb_q.size());
            end
            if (sb_q.size() != 0) begin
                want = sb_q.pop_front();
                checks++;
                assert (got === want) else begin
                    errors++;
                    $error("FAIL sb_pixel: got x=%0d y=%0d de=%b rgb=%h sof=%b eol=%b lk=%b err=%b, required x=%0d y=%0d de=%b rgb=%h sof=%b eol=%b lk=%b err=%b",
                           got.x, got.y, got.de, got.prgb, got.sof, got.eol, got.locked, got.err,
                           want.x, want.y, want.de, want.prgb, want.sof, want.eol, want.locked, want.err);
                end
            end
            if (de)  de_cnt++;
            if (eol) eol_cnt++;
            if (sof) sof_cnt++;
            if (err) begin
                err_cnt++;
                h_meas_at_err = h_meas;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int h, input int v, input logic [CD-1:0] c,
                                    input logic lk, input logic er);
        exp_t e;
        logic act;
        act      = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        e.x      = act ? 11'(h - (HS + HB)) : 11'd0;
        e.y      = act ? 11'(v - (VS + VB)) : 11'd0;
        e.de     = act && lk;
        e.prgb   = e.de ? c : '0;
        e.sof    = e.de && (e.x == 11'd0) && (e.y == 11'd0);
        e.eol    = e.de && (e.x == 11'(HA - 1));
        e.locked = lk;
        e.err    = er;
        return e;
    endfunction

    function automatic logic [15:0] crc_ref(input int n, input logic [15:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 15; b >= 0; b--)
                c = (c[15] ^ d[b]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // Called just after a negedge: pulse pix_tick for one clk, period tick_div.
    task automatic send_tick(input logic hs, input logic vs, input logic [CD-1:0] c, input exp_t e);
        sb_q.push_back(e);
        hsync    = hs;
        vsync    = vs;
        rgb      = c;
        pix_tick = 1'b1;
        @(negedge clk);
        pix_tick = 1'b0;
        repeat (tick_div - 1) @(negedge clk);
    endtask

    // One frame, sync at the start of line/frame. long_line gets one extra
    // tick; the error is then expected on the next line's hsync edge.
    task automatic send_frame(input logic lk0, input logic lk_rest, input int long_line,
                              input int max_ticks, input logic const_rgb);
        int            n;
        int            hlen;
        logic          lk, er, failed;
        logic [CD-1:0] c;
        n      = 0;
        failed = 1'b0;
        for (int v = 0; v < VT; v++) begin
            hlen = (v == long_line) ? HT + 1 : HT;
            for (int h = 0; h < hlen; h++) begin
                if (max_ticks >= 0 && n == max_ticks) return;
                er = (long_line >= 0) && (v == long_line + 1) && (h == 0);
                if (er) failed = 1'b1;
                lk = (v == 0 && h == 0) ? lk0 : (lk_rest && !failed);
                c  = const_rgb ? 12'hF00 : CD'((h * 37 + v * 11) ^ 'h5A5);
                send_tick((h < HS) ? POL_L : ~POL_L, (v < VS) ? POL_L : ~POL_L, c,
                          mk_exp(h, v, c, lk, er));
                n++;
            end
        end
    endtask

    int          d0, e0, s0, vld_seen;
    logic [15:0] crc_exp;

    initial begin
        reset    = 1'b1;
        pix_tick = 1'b0;
        hsync    = ~POL_L;
        vsync    = ~POL_L;
        rgb      = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({pix_vld, x, y, de, pix_rgb, sof, eol, locked, err, h_meas, v_meas, frame_crc}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Acquisition: first vsync edge -> CHECK, second -> LOCKED.
        send_frame(1'b0, 1'b0, -1, -1, 1'b0);
        @(negedge clk);
        chk("lock_after_1_vsync", 64'(locked), 64'd0);
        send_frame(1'b1, 1'b1, -1, -1, 1'b0);
        @(negedge clk);
        chk("lock_after_2_vsync", 64'(locked), 64'd1);

        d0 = de_cnt; e0 = eol_cnt; s0 = sof_cnt;
        send_frame(1'b1, 1'b1, -1, -1, 1'b0);
        @(negedge clk);
        chk("de_per_frame", 64'(de_cnt - d0), 64'(HA * VA));
        chk("eol_per_frame", 64'(eol_cnt - e0), 64'(VA));
        chk("sof_per_frame", 64'(sof_cnt - s0), 64'd1);
        chk("h_meas_ideal", 64'(h_meas), 64'(HT));
        chk("v_meas_ideal", 64'(v_meas), 64'(VT));
        chk("no_err_ideal", 64'(err_cnt), 64'd0);

        // One long line while locked, then relock over two clean vsync edges.
        tick_div = 2;
        send_frame(1'b1, 1'b1, 3, -1, 1'b0);
        @(negedge clk);
        chk("err_long_line", 64'(err_cnt), 64'd1);
        chk("h_meas_long_line", 64'(h_meas_at_err), 64'(HT + 1));
        chk("unlocked_after_err", 64'(locked), 64'd0);
        send_frame(1'b0, 1'b0, -1, -1, 1'b0);
        send_frame(1'b1, 1'b1, -1, -1, 1'b0);
        @(negedge clk);
        chk("relocked", 64'(locked), 64'd1);

        // hsync stuck deasserted: h_cnt continues from 27 and saturates at 2047.
        for (int k = 1; k <= 2100; k++)
            send_tick(~POL_L, ~POL_L, 12'h123, mk_exp(HT - 1 + k, VT - 1, 12'h123, k < 2020, k == 2020));
        @(negedge clk);
        chk("err_saturation", 64'(err_cnt), 64'd2);
        chk("search_after_sat", 64'(locked), 64'd0);

        // Relock, then a constant-colour locked frame for the CRC.
        send_frame(1'b0, 1'b0, -1, -1, 1'b0);
        send_frame(1'b1, 1'b1, -1, -1, 1'b1);
        send_frame(1'b1, 1'b1, -1, 6 * HT + 10, 1'b0);
        @(negedge clk);
        chk("v_meas_relock", 64'(v_meas), 64'(VT));
`ifdef VGA_RX_CRC_EN
        crc_exp = crc_ref(HA * VA, 16'h0F00);
`else
        crc_exp = 16'h0000;
`endif
        chk("frame_crc", 64'(frame_crc), 64'(crc_exp));
        chk("locked_before_reset", 64'(locked), 64'd1);

        // Reset mid-line: outputs clear at once, no pix_vld until a new tick.
        reset = 1'b1;
        #1;
        chk("reset_mid_line", 64'({pix_vld, x, y, de, pix_rgb, sof, eol, locked, err, h_meas, v_meas, frame_crc}), 64'd0);
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pix_vld) vld_seen++;
        end
        chk("no_vld_after_reset", 64'(vld_seen), 64'd0);

        s0 = sof_cnt;
        send_frame(1'b0, 1'b0, -1, -1, 1'b0);
        @(negedge clk);
        chk("not_locked_1_vsync", 64'(locked), 64'd0);
        send_frame(1'b1, 1'b1, -1, -1, 1'b0);
        @(negedge clk);
        chk("relock_after_reset", 64'(locked), 64'd1);
        chk("sof_after_relock", 64'(sof_cnt - s0), 64'd1);
        chk("err_total", 64'(err_cnt), 64'd2);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
